// File: rtl/result_stream_reader.sv
// result_stream_reader: sweeps a region of the wide data memory and streams each word out lane by lane.
module result_stream_reader #(
  parameter int MEM_WIDTH  = 12,
  parameter int CORE_COUNT = 3,
  parameter int MEM_ADDR   = 11
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic [MEM_ADDR-1:0]             baseAddr,
  input  logic [MEM_ADDR:0]               wordCount,
  output logic [MEM_ADDR-1:0]             memAddr,
  input  logic [MEM_WIDTH*CORE_COUNT-1:0] memDataIn,
  output logic [MEM_WIDTH-1:0]            outData,
  output logic                            outValid,
  input  logic                            outReady,
  output logic                            outLast,
  output logic                            busy,
  output logic                            done
);
  localparam int LW = CORE_COUNT > 1 ? $clog2(CORE_COUNT) : 1;
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND, FINISH} state_t;
  state_t state, stateNext;
  logic [MEM_ADDR-1:0] base;
  logic [MEM_ADDR:0] count, idx;
  logic [LW-1:0] lane;
  logic [MEM_WIDTH*CORE_COUNT-1:0] word;
  logic lastLane, lastWord, xfer;
  assign lastLane = lane == LW'(CORE_COUNT - 1);
  assign lastWord = idx == count - (MEM_ADDR+1)'(1);
  assign outValid = state == SEND;
  assign busy = state != IDLE;
  assign done = state == FINISH;
  assign xfer = outValid && outReady;
  assign outLast = outValid && lastWord && lastLane;
  assign outData = outValid ? word[lane*MEM_WIDTH +: MEM_WIDTH] : '0;
  // index never exceeds count-1, so its low bits give the wrapped offset
  assign memAddr = busy ? base + idx[MEM_ADDR-1:0] : '0;
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= stateNext;
  always_comb begin
    stateNext = IDLE;
    case (state)
      IDLE:    stateNext = !start ? IDLE : wordCount == '0 ? FINISH : READ;
      READ:    stateNext = CAPTURE;
      CAPTURE: stateNext = SEND;
      SEND:    stateNext = !xfer || !lastLane ? SEND : lastWord ? FINISH : READ;
      default: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge clock)
    if (reset) begin
      base <= '0;
      count <= '0;
      idx <= '0;
      lane <= '0;
      word <= '0;
    end else begin
      if (state == IDLE && start) begin
        base <= baseAddr;
        count <= wordCount;
        idx <= '0;
      end
      if (state == CAPTURE) begin
        word <= memDataIn;
        lane <= '0;
      end
      if (xfer && !lastLane) lane <= lane + LW'(1);
      if (xfer && lastLane && !lastWord) idx <= idx + (MEM_ADDR+1)'(1);
    end
endmodule

// File: tb/tb_result_stream_reader.sv
// tb_result_stream_reader: table-driven sweeps against a memory model with a lane scoreboard.
module tb_result_stream_reader;
  logic clock, reset, start, outValid, outReady, outLast, busy, done;
  logic [10:0] baseAddr, memAddr;
  logic [11:0] wordCount;
  logic [35:0] memDataIn;
  logic [11:0] outData;
  logic [35:0] mem [2048];
  typedef struct {logic [11:0] data; logic last;} lane_t;
  typedef struct {logic [10:0] base; logic [11:0] count; bit stall; bit disturb; int expDone;} vec_t;
  lane_t q[$];
  vec_t vecs[$];
  int errors = 0, checks = 0, cyc;
  logic pValid = 0, pReady = 0, pLast = 0;
  logic [11:0] pData = 0;

  result_stream_reader dut (.clock(clock), .reset(reset), .start(start), .baseAddr(baseAddr),
    .wordCount(wordCount), .memAddr(memAddr), .memDataIn(memDataIn), .outData(outData),
    .outValid(outValid), .outReady(outReady), .outLast(outLast), .busy(busy), .done(done));

  initial clock = 0;
  always #5 clock = ~clock;
  always @(posedge clock) memDataIn <= mem[memAddr];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    lane_t e;
    if (outValid && outReady) begin
      if (q.size() == 0) check("extraTransfer", {outValid, outData}, 0);
      else begin
        e = q.pop_front();
        check("laneData", outData, e.data);
        check("laneLast", outLast, e.last);
      end
    end
    if (!outValid) check("idleData", {outLast, outData}, 0);
    if (pValid && !pReady && !reset) check("stallHold", {outValid, outLast, outData}, {1'b1, pLast, pData});
    pValid = outValid; pReady = outReady; pData = outData; pLast = outLast;
  endtask

  task automatic tick(input logic rdy);
    @(posedge clock);
    #1 start = 0;
    outReady = rdy;
    @(negedge clock);
    cyc++;
    monitor();
  endtask

  task automatic pushExpect(input logic [10:0] base, input logic [11:0] count);
    logic [10:0] a;
    for (int w = 0; w < count; w++) begin
      a = base + 11'(w);
      for (int l = 0; l < 3; l++) q.push_back('{mem[a][l*12 +: 12], w == count - 1 && l == 2});
    end
  endtask

  task automatic runSweep(input vec_t v);
    int doneAt = -1, firstV = -1;
    logic [35:0] saved;
    pushExpect(v.base, v.count);
    baseAddr = v.base; wordCount = v.count; start = 1; cyc = 0;
    saved = mem[v.base];
    for (int i = 0; i < 12000 && doneAt < 0; i++) begin
      tick(v.stall ? 1'($urandom_range(0, 1)) : 1'b1);
      if (outValid && firstV < 0) firstV = cyc;
      if (done) doneAt = cyc;
      if (cyc == 1) check("busyEarly", busy, 1);
      if (cyc == 1 && v.count != 0) check("firstAddr", memAddr, v.base);
      if (v.disturb && cyc == 4) begin
        start = 1; baseAddr = v.base + 11'd500; wordCount = 12'd1;
        mem[v.base] = ~saved;
      end
    end
    mem[v.base] = saved;
    check("doneSeen", doneAt >= 0, 1);
    if (v.expDone >= 0) check("doneCycle", doneAt, v.expDone);
    if (v.count != 0) check("firstValid", firstV, 3);
    else check("noValid", firstV, -1);
    tick(1);
    check("afterDone", {done, busy}, 0);
    check("queueEmpty", q.size(), 0);
    q.delete();
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = {12'(a * 5 + 1), 12'(a) ^ 12'hA5A, 12'(a)};
    mem[5] = 36'h00A00B00C;
    mem[6] = 36'h123456789;
    vecs = '{'{11'd5, 12'd2, 1'b0, 1'b0, 11}, '{11'd5, 12'd2, 1'b1, 1'b0, -1},
             '{11'd2046, 12'd3, 1'b0, 1'b0, 16}, '{11'd0, 12'd0, 1'b0, 1'b0, 1},
             '{11'd100, 12'd1, 1'b0, 1'b0, 6}, '{11'd5, 12'd2, 1'b0, 1'b1, 11},
             '{11'd7, 12'd2048, 1'b0, 1'b0, 10241}};
    reset = 1; start = 0; baseAddr = 0; wordCount = 0; outReady = 1; cyc = 0;
    repeat (3) tick(1);
    check("resetOutputs", {memAddr, outData, outValid, outLast, busy, done}, 0);
    reset = 0;
    tick(1);
    // known lane values of the first region, independent of the memory model
    q.push_back('{12'h00C, 0}); q.push_back('{12'h00B, 0}); q.push_back('{12'h00A, 0});
    q.push_back('{12'h789, 0}); q.push_back('{12'h456, 0}); q.push_back('{12'h123, 1});
    baseAddr = 5; wordCount = 2; start = 1; cyc = 0;
    while (cyc < 11) tick(1);
    check("knownDone", done, 1);
    check("knownQueue", q.size(), 0);
    tick(1);
    foreach (vecs[i]) runSweep(vecs[i]);
    pushExpect(11'd5, 12'd2);
    baseAddr = 5; wordCount = 2; start = 1; cyc = 0;
    while (cyc < 8) tick(1);
    tick(0);
    check("preResetLane", {outValid, outData}, {1'b1, 12'h456});
    reset = 1;
    tick(0);
    check("abortOutputs", {memAddr, outData, outValid, outLast, busy, done}, 0);
    reset = 0;
    begin
      logic bad = 0;
      repeat (5) begin tick(1); bad |= done | outValid | busy; end
      check("abortQuiet", bad, 0);
    end
    q.delete();
    runSweep('{11'd5, 12'd2, 1'b0, 1'b0, 11});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
